// File: rtl/alu_share_ctrl_if.sv
// Request, response and ALU-drive signals of alu_share_ctrl, grouped for port passing.
interface alu_share_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3,
  parameter int CNTW  = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [OPW-1:0]   req0_op;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [OPW-1:0]   req1_op;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_illegal;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_ctrl;
  logic [WIDTH-1:0] alu_result;
  logic             busy;
  logic [CNTW-1:0]  op_count;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp0_ready, rsp1_ready, alu_result,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_result, rsp_zero, rsp_illegal,
    output alu_a, alu_b, alu_ctrl, busy, op_count
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp0_ready, rsp1_ready, alu_result,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_result, rsp_zero, rsp_illegal,
    input  alu_a, alu_b, alu_ctrl, busy, op_count
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one combinational ALU between two requesters; accept-to-response 2 cycles.
// Requests stall in IDLE-only acceptance; a response is held indefinitely until its port takes it.
module alu_share_ctrl #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3,
  parameter int CNTW  = 16
) (
  input  logic           clk,
  input  logic           reset,
  alu_share_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last_grant;
  logic             r_owner;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [OPW-1:0]   r_alu_ctrl;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_illegal;
  logic [CNTW-1:0]  r_op_count;

  logic             w_grant;
  logic             w_accept;
  logic             w_rsp_done;
  logic             w_op_illegal;
  logic [WIDTH-1:0] w_capture;

  // A lone requester wins outright; on a tie the port that did not win last time goes.
  always_comb begin
    w_grant = ~r_last_grant;
    if (bus.req0_valid && !bus.req1_valid) begin
      w_grant = 1'b0;
    end else if (!bus.req0_valid && bus.req1_valid) begin
      w_grant = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_accept       = 1'b0;
    w_rsp_done     = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    case (r_state)
      IDLE: begin
        bus.req0_ready = bus.req0_valid && !w_grant;
        bus.req1_ready = bus.req1_valid && w_grant;
        w_accept       = (bus.req0_valid && !w_grant) || (bus.req1_valid && w_grant);
        if (w_accept) begin
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        w_state_nxt = RESP;
      end
      RESP: begin
        bus.rsp0_valid = !r_owner;
        bus.rsp1_valid = r_owner;
        w_rsp_done     = r_owner ? bus.rsp1_ready : bus.rsp0_ready;
        if (w_rsp_done) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Opcodes with the top bit set are outside the ALU encoding; their result is forced to zero.
  assign w_op_illegal = r_alu_ctrl[OPW-1];
  assign w_capture    = w_op_illegal ? '0 : bus.alu_result;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_ctrl   <= '0;
      r_result     <= '0;
      r_zero       <= 1'b0;
      r_illegal    <= 1'b0;
      r_op_count   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_alu_a      <= w_grant ? bus.req1_a  : bus.req0_a;
        r_alu_b      <= w_grant ? bus.req1_b  : bus.req0_b;
        r_alu_ctrl   <= w_grant ? bus.req1_op : bus.req0_op;
        r_owner      <= w_grant;
        r_last_grant <= w_grant;
      end
      if (r_state == EXEC) begin
        r_result  <= w_capture;
        r_zero    <= (w_capture == '0);
        r_illegal <= w_op_illegal;
      end
      if (w_rsp_done && (r_op_count != '1)) begin
        r_op_count <= r_op_count + 1'b1;
      end
    end
  end

  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_ctrl    = r_alu_ctrl;
  assign bus.rsp_result  = r_result;
  assign bus.rsp_zero    = r_zero;
  assign bus.rsp_illegal = r_illegal;
  assign bus.busy        = (r_state != IDLE);
  assign bus.op_count    = r_op_count;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl with a behavioural ALU attached to the ALU drive.
module tb_alu_share_ctrl;
  localparam int WIDTH = 32;
  localparam int OPW   = 3;
  localparam int CNTW  = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_share_ctrl_if #(.WIDTH(WIDTH), .OPW(OPW), .CNTW(CNTW)) bus ();
  alu_share_ctrl #(.WIDTH(WIDTH), .OPW(OPW), .CNTW(CNTW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Undefined opcodes return a non-zero pattern so a missing illegal override is visible.
  always_comb begin
    case (bus.alu_ctrl)
      3'b000:  bus.alu_result = bus.alu_a + bus.alu_b;
      3'b001:  bus.alu_result = bus.alu_a & bus.alu_b;
      3'b010:  bus.alu_result = bus.alu_a | bus.alu_b;
      3'b011:  bus.alu_result = bus.alu_a ^ bus.alu_b;
      default: bus.alu_result = bus.alu_a ^ bus.alu_b ^ 32'hDEAD_BEEF;
    endcase
  end

  typedef struct {
    bit          port;
    logic [31:0] res;
    bit          zero;
    bit          ill;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   order[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   exp_cnt = 0;
  bit   was_v[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a & b;
      3'b010:  return a | b;
      3'b011:  return a ^ b;
      default: return 32'h0;
    endcase
  endfunction

  task automatic set_req(input bit port, input bit v, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
    if (port) begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end else begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end
  endtask

  task automatic send(input bit port, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    exp_t e;
    int   n;
    @(negedge clk);
    set_req(port, 1'b1, a, b, op);
    n = 0;
    forever begin
      #1;
      if ((port ? bus.req1_ready : bus.req0_ready) === 1'b1) break;
      n++;
      if (n > 60) begin
        check("req_timeout", 32'd0, 32'd1);
        set_req(port, 1'b0, '0, '0, '0);
        return;
      end
      @(negedge clk);
    end
    e.port = port;
    e.res  = model(a, b, op);
    e.zero = (e.res == 32'h0);
    e.ill  = op[2];
    e.acc  = cyc;
    sb.push_back(e);
    order.push_back(int'(port));
    @(posedge clk);
    #1;
    set_req(port, 1'b0, '0, '0, '0);
  endtask

  task automatic mon_port(input bit p);
    logic vld, rdy;
    exp_t e;
    vld = p ? bus.rsp1_valid : bus.rsp0_valid;
    rdy = p ? bus.rsp1_ready : bus.rsp0_ready;
    if (vld && !was_v[p]) begin
      if (sb.size() == 0) check("unexpected_rsp", 32'(p), 32'hFFFF_FFFF);
      else check("latency", 32'(cyc - sb[0].acc), 32'd2);
    end
    was_v[p] = vld;
    if (vld && rdy && sb.size() != 0) begin
      e = sb.pop_front();
      check("rsp_port", 32'(p), 32'(e.port));
      check("rsp_result", bus.rsp_result, e.res);
      check("rsp_zero", 32'(bus.rsp_zero), 32'(e.zero));
      check("rsp_illegal", 32'(bus.rsp_illegal), 32'(e.ill));
      check("rsp_excl", 32'(bus.rsp0_valid & bus.rsp1_valid), 32'd0);
      if (exp_cnt != 32'hFFFF) exp_cnt++;
      @(posedge clk);
      #1;
      check("op_count", 32'(bus.op_count), 32'(exp_cnt));
      was_v[p] = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        mon_port(1'b0);
        mon_port(1'b1);
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("drain_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ord[4];
    exp_ord = '{0, 1, 0, 1};
    reset = 1'b1;
    set_req(1'b0, 1'b0, '0, '0, '0);
    set_req(1'b1, 1'b0, '0, '0, '0);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    check("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_alu_b", bus.alu_b, 32'd0);
    check("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
    check("rst_result", bus.rsp_result, 32'd0);
    check("rst_zero", 32'(bus.rsp_zero), 32'd0);
    check("rst_illegal", 32'(bus.rsp_illegal), 32'd0);
    check("rst_op_count", 32'(bus.op_count), 32'd0);

    // Both ports contend from reset: port 0 must take the first tie, then alternate.
    order.delete();
    fork
      begin send(1'b0, 32'h11, 32'h22, 3'b000); send(1'b0, 32'hFF00, 32'h0FF0, 3'b010); end
      begin send(1'b1, 32'h5, 32'h3, 3'b011);   send(1'b1, 32'hA, 32'hA, 3'b011);     end
    join
    drain();
    check("grant_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4 && i < order.size(); i++) check("grant_order", 32'(order[i]), 32'(exp_ord[i]));

    send(1'b0, 32'h7, 32'h9, 3'b000);
    send(1'b1, 32'hF0F0, 32'h0F0F, 3'b001);
    send(1'b1, 32'hF0F0, 32'h0F0F, 3'b011);
    send(1'b0, 32'hFFFF_FFFF, 32'h1, 3'b000);
    send(1'b0, 32'h1, 32'h1, 3'b101);
    send(1'b0, 32'h1, 32'h1, 3'b010);
    send(1'b1, 32'h1, 32'h2, 3'b111);
    drain();

    // Response backpressure on port 0 while port 1 waits.
    bus.rsp0_ready = 1'b0;
    send(1'b0, 32'h1234_5678, 32'h1, 3'b000);
    fork
      send(1'b1, 32'h5, 32'h6, 3'b000);
      begin
        @(negedge clk);
        repeat (5) begin
          @(negedge clk);
          #3;
          check("hold_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
          check("hold_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
          check("hold_result", bus.rsp_result, 32'h1234_5679);
          check("hold_busy", 32'(bus.busy), 32'd1);
          check("hold_req1_ready", 32'(bus.req1_ready), 32'd0);
        end
        @(negedge clk);
        bus.rsp0_ready = 1'b1;
      end
    join
    drain();

    // Reset while the operation sits in EXEC discards it.
    send(1'b0, 32'h3, 32'h4, 3'b000);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    sb.delete();
    order.delete();
    exp_cnt = 0;
    was_v[0] = 1'b0;
    was_v[1] = 1'b0;
    #1;
    check("rr_busy", 32'(bus.busy), 32'd0);
    check("rr_op_count", 32'(bus.op_count), 32'd0);
    repeat (4) begin
      @(negedge clk);
      #3;
      check("rr_no_rsp", 32'(bus.rsp0_valid | bus.rsp1_valid), 32'd0);
    end
    fork
      send(1'b0, 32'h20, 32'h22, 3'b000);
      send(1'b1, 32'h30, 32'h0F, 3'b010);
    join
    drain();
    check("rr_grant_count", 32'(order.size()), 32'd2);
    if (order.size() >= 2) begin
      check("rr_first_grant", 32'(order[0]), 32'd0);
      check("rr_second_grant", 32'(order[1]), 32'd1);
    end
    check("final_op_count", 32'(bus.op_count), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Sequencing controller that shares one combinational 32-bit ALU between two requesters (port 0, port 1).
- Accepts operand/opcode requests over valid/ready handshakes and arbitrates round-robin.
- Drives the ALU operand and control inputs from registers and captures the result.
- Returns the result, a locally computed zero flag and an illegal-op flag on a per-port response handshake.

Parameters:
- WIDTH, 32, operand/result width.
- OPW, 3, opcode width; matches the ALU control encoding (000 add, 001 and, 010 or, 011 xor).
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req0_valid / req1_valid  in  1  request valid.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands.
- req0_op / req1_op  in  OPW  opcode.
- rsp0_valid / rsp1_valid  out  1  response valid.
- rsp0_ready / rsp1_ready  in  1  response consumed.
- rsp_result  out  WIDTH  result, shared by both ports; qualified by rspN_valid.
- rsp_zero  out  1  result equals zero.
- rsp_illegal  out  1  opcode was outside 000–011.
- alu_a, alu_b  out  WIDTH  ALU operand drive.
- alu_ctrl  out  OPW  ALU control drive.
- alu_result  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_ctrl).
- busy  out  1  state is not IDLE.
- op_count  out  CNTW  completed responses, saturating.

Behaviour:
- Reset values: state=IDLE, all ready/valid outputs 0, alu_a/alu_b/alu_ctrl=0, rsp_result=0, rsp_zero=0, rsp_illegal=0, op_count=0, last_grant=1 (so port 0 wins the first tie).
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner selection: if only one reqN_valid is high, that port wins. If both are high, the port != last_grant wins.
  - reqN_ready is combinational: 1 only for the winner, only in IDLE, only while its valid is high. The loser sees ready=0.
  - On a handshake (valid & ready at the clock edge): register a, b, op and owner into alu_a/alu_b/alu_ctrl/owner; set last_grant=owner; go to EXEC.
- EXEC (exactly 1 cycle):
  - ALU inputs are stable from registers.
  - At the edge, capture rsp_result = alu_result, unless op[2]=1: then rsp_result=0 and rsp_illegal=1.
  - rsp_zero = (captured value == 0), computed by this block. The ALU's own zero output is not used.
  - Go to RESP.
- RESP:
  - rsp<owner>_valid=1; the other port's rsp valid stays 0.
  - Result/zero/illegal are held stable while rsp_ready=0 (backpressure unbounded).
  - On rsp<owner>_ready=1 at the edge: drop valid, increment op_count (saturate at all-ones), go to IDLE.
- No new request is accepted outside IDLE. Latency is accept edge → rsp_valid visible 2 cycles later. Minimum spacing between accepts is 3 cycles.
- Requesters must hold a/b/op stable while valid=1 and ready=0. Deasserting valid before ready is permitted and drops the request with no side effects.
- alu_a/alu_b/alu_ctrl keep their last values in RESP and IDLE; they are updated only on accept.
- rspN_ready asserted while rspN_valid=0 is ignored.
- Reset asserted in any state:
  - Immediately forces IDLE and all reset values.
  - Any in-flight operation is discarded; no response is produced.
  - op_count clears to 0.
- Addition wraps modulo 2^WIDTH; no carry is reported.

Test Plan:
1. Port 0 only: a=0x7, b=0x9, op=000 → req0_ready same cycle; rsp0_valid 2 cycles after accept; result 0x10, zero=0, illegal=0; op_count=1.
2. Port 1: a=0xF0F0, b=0x0F0F, op=001 → result 0x0, zero=1. Then op=011 on the same operands → result 0xFFFF, zero=0.
3. Both valid from reset, each holding 2 requests → grant order 0,1,0,1; loser ready stays 0 until its turn; rsp1_valid never high during a port-0 response.
4. op=101, a=0x1, b=0x1 → rsp_result=0, zero=1, illegal=1, same 2-cycle latency; next legal op has illegal=0.
5. rsp0_ready held 0 for 5 cycles in RESP → rsp0_valid and result stable; busy=1; req1_ready=0 throughout; accepted on cycle 6.
6. Reset pulse during EXEC → next cycle busy=0, no rsp valid ever appears for that op, op_count=0. Then a fresh request completes normally with port 0 winning a tie.
